// File: rtl/uart_proto_pkg.sv
// uart_proto_pkg
// Shared definitions for the debug-path UART line parsers: the ASCII
// constants used by the ACK grammar, the parser FSM state type and the
// error cause type reported on err_code.
package uart_proto_pkg;

  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_C  = 8'h43;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GOT_A  = 3'd1,
    ST_GOT_C  = 3'd2,
    ST_GOT_K  = 3'd3,
    ST_DIGITS = 3'd4,
    ST_RESYNC = 3'd5
  } ack_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_CHAR = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_EMPTY    = 2'd3
  } ack_err_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

// File: rtl/uart_dec_accum.sv
// uart_dec_accum
// Decimal accumulator for the ACK line parser. Each accepted digit does
// value = value*10 + digit. The overflow flag is combinational on the
// candidate next value (and on the digit count) so the FSM can reject the
// offending digit in the same cycle it arrives; a rejected digit leaves
// the accumulator unchanged.
//   clk, rst_n  clock, async active-low reset
//   clear       zero value and digit count (start of a number)
//   digit_stb   a digit is presented on digit_val this cycle
//   digit_val   binary digit 0..9
//   value       accumulated value
//   digit_cnt   number of digits accepted so far
//   overflow    presenting digit_val now would exceed the value range
//               or the digit limit
module uart_dec_accum #(
  parameter int VALUE_W    = 16,
  parameter int MAX_DIGITS = 5,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               digit_stb,
  input  logic [3:0]         digit_val,
  output logic [VALUE_W-1:0] value,
  output logic [CNT_W-1:0]   digit_cnt,
  output logic               overflow
);

  localparam int NW = VALUE_W + 4;
  localparam logic [NW-1:0] LIMIT = {4'b0000, {VALUE_W{1'b1}}};

  logic [VALUE_W-1:0] r_value;
  logic [CNT_W-1:0]   r_cnt;
  logic [NW-1:0]      w_next;

  // 4 guard bits hold (2^VALUE_W-1)*10+9 without wrapping
  assign w_next   = ({4'b0000, r_value} * NW'(10)) + NW'(digit_val);
  assign overflow = (w_next > LIMIT) || (r_cnt == CNT_W'(MAX_DIGITS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else if (clear) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else if (digit_stb && !overflow) begin
      r_value <= w_next[VALUE_W-1:0];
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign value     = r_value;
  assign digit_cnt = r_cnt;

endmodule

// File: rtl/uart_ack_parser.sv
// uart_ack_parser
// Recognises "ACK <decimal>\n" lines in the byte stream from uart_rx.
// A good line loads ack_value and pulses ack_valid; a malformed line
// pulses parse_err once with a cause on err_code, then bytes are dropped
// until the next newline. CR is ignored everywhere.
//   clk, rst_n   clock, async active-low reset
//   in_data      received byte, consumed when in_valid is high
//   in_valid     byte strobe, may be high every cycle
//   ack_value    last parsed value, held until the next success
//   ack_valid    one-cycle strobe per good line
//   parse_err    one-cycle strobe per bad line
//   err_code     last error cause (ack_err_t), held until the next error
//   ack_count    good-line counter, wraps at 256
//   state_dbg    current FSM state
//
// state     | meaning
// ST_IDLE   | start of line, expecting 'A'
// ST_GOT_A  | "A" seen, expecting 'C'
// ST_GOT_C  | "AC" seen, expecting 'K'
// ST_GOT_K  | "ACK" seen, expecting space
// ST_DIGITS | accumulating decimal digits until '\n'
// ST_RESYNC | line already failed, dropping bytes until '\n'
module uart_ack_parser
  import uart_proto_pkg::*;
#(
  parameter int VALUE_W    = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic [VALUE_W-1:0] ack_value,
  output logic               ack_valid,
  output logic               parse_err,
  output logic [1:0]         err_code,
  output logic [7:0]         ack_count,
  output logic [2:0]         state_dbg
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  ack_state_t         r_state;
  ack_state_t         w_state_nxt;
  logic               w_ack;
  logic               w_err;
  ack_err_t           w_err_code;
  logic               w_clear;
  logic               w_digit_stb;
  logic               w_overflow;
  logic [VALUE_W-1:0] w_acc_value;
  logic [CNT_W-1:0]   w_digit_cnt;

  logic [VALUE_W-1:0] r_ack_value;
  logic               r_ack_valid;
  logic               r_parse_err;
  ack_err_t           r_err_code;
  logic [7:0]         r_ack_count;

  uart_dec_accum #(
    .VALUE_W    (VALUE_W),
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_clear),
    .digit_stb (w_digit_stb),
    .digit_val (in_data[3:0]),
    .value     (w_acc_value),
    .digit_cnt (w_digit_cnt),
    .overflow  (w_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    w_err_code  = ERR_NONE;
    w_clear     = 1'b0;
    w_digit_stb = 1'b0;
    if (in_valid && (in_data != CH_CR)) begin
      case (r_state)
        ST_IDLE: begin
          if (in_data == CH_A) begin
            w_state_nxt = ST_GOT_A;
          end else if (in_data != CH_LF) begin
            w_err       = 1'b1;
            w_err_code  = ERR_BAD_CHAR;
            w_state_nxt = ST_RESYNC;
          end
        end
        ST_GOT_A, ST_GOT_C, ST_GOT_K: begin
          if ((r_state == ST_GOT_A) && (in_data == CH_C)) begin
            w_state_nxt = ST_GOT_C;
          end else if ((r_state == ST_GOT_C) && (in_data == CH_K)) begin
            w_state_nxt = ST_GOT_K;
          end else if ((r_state == ST_GOT_K) && (in_data == CH_SP)) begin
            w_state_nxt = ST_DIGITS;
            w_clear     = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_err_code = ERR_BAD_CHAR;
            // a newline already ends the line, so no resync is needed
            if (in_data == CH_LF) w_state_nxt = ST_IDLE;
            else                  w_state_nxt = ST_RESYNC;
          end
        end
        ST_DIGITS: begin
          if (is_digit(in_data)) begin
            w_digit_stb = 1'b1;
            if (w_overflow) begin
              w_err       = 1'b1;
              w_err_code  = ERR_OVERFLOW;
              w_state_nxt = ST_RESYNC;
            end
          end else if (in_data == CH_LF) begin
            w_state_nxt = ST_IDLE;
            if (w_digit_cnt != '0) begin
              w_ack = 1'b1;
            end else begin
              w_err      = 1'b1;
              w_err_code = ERR_EMPTY;
            end
          end else begin
            w_err       = 1'b1;
            w_err_code  = ERR_BAD_CHAR;
            w_state_nxt = ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          if (in_data == CH_LF) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_value <= '0;
      r_ack_valid <= 1'b0;
      r_parse_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_ack_count <= '0;
    end else begin
      r_ack_valid <= w_ack;
      r_parse_err <= w_err;
      if (w_ack) begin
        r_ack_value <= w_acc_value;
        r_ack_count <= r_ack_count + 8'd1;
      end
      if (w_err) r_err_code <= w_err_code;
    end
  end

  assign ack_value = r_ack_value;
  assign ack_valid = r_ack_valid;
  assign parse_err = r_parse_err;
  assign err_code  = r_err_code;
  assign ack_count = r_ack_count;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_uart_ack_parser.sv
// tb_uart_ack_parser
// Drives directed ACK lines and randomised (corrupted, truncated, gapped)
// lines into uart_ack_parser and compares every output each cycle with a
// line-level reference model that re-evaluates the line text so far.
module tb_uart_ack_parser;

  localparam int VALUE_W    = 16;
  localparam int MAX_DIGITS = 5;
  localparam longint VMAX   = (64'd1 << VALUE_W) - 1;

  logic               clk;
  logic               rst_n;
  logic [7:0]         in_data;
  logic               in_valid;
  logic [VALUE_W-1:0] ack_value;
  logic               ack_valid;
  logic               parse_err;
  logic [1:0]         err_code;
  logic [7:0]         ack_count;
  logic [2:0]         state_dbg;

  uart_ack_parser #(.VALUE_W(VALUE_W), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .ack_value (ack_value),
    .ack_valid (ack_valid),
    .parse_err (parse_err),
    .err_code  (err_code),
    .ack_count (ack_count),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_err_pulses = 0;

  // reference model: the current line text plus a "line already failed" flag
  logic [7:0] q_line[$];
  bit         dead;
  logic       exp_av, exp_pe;
  longint     exp_val;
  int         exp_err;
  logic [7:0] exp_cnt;
  logic [7:0] hdr[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    q_line.delete();
    dead    = 0;
    exp_av  = 0;
    exp_pe  = 0;
    exp_val = 0;
    exp_err = 0;
    exp_cnt = 0;
  endtask

  task automatic model_error(input int code, input bit kill);
    exp_pe  = 1;
    exp_err = code;
    q_line.delete();
    dead    = kill;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int     n;
    longint v;
    if (b == 8'h0D) return;
    if (dead) begin
      if (b == 8'h0A) dead = 0;
      return;
    end
    n = q_line.size();
    if (b == 8'h0A) begin
      if (n == 0) return;
      if (n < 4) begin model_error(1, 0); return; end
      if (n == 4) begin model_error(3, 0); return; end
      v = 0;
      for (int i = 4; i < n; i++) v = v * 10 + longint'(int'(q_line[i]) - 48);
      exp_av  = 1;
      exp_val = v;
      exp_cnt = exp_cnt + 8'd1;
      q_line.delete();
      return;
    end
    q_line.push_back(b);
    if (n < 4) begin
      if (b != hdr[n]) model_error(1, 1);
    end else if (b < 8'h30 || b > 8'h39) begin
      model_error(1, 1);
    end else begin
      v = 0;
      for (int i = 4; i <= n; i++) v = v * 10 + longint'(int'(q_line[i]) - 48);
      if ((n + 1 - 4) > MAX_DIGITS || v > VMAX) model_error(2, 1);
    end
  endtask

  function automatic logic [2:0] exp_state();
    if (dead) return 3'd5;
    if (q_line.size() >= 4) return 3'd4;
    return 3'(q_line.size());
  endfunction

  task automatic check_all();
    chk("ack_valid", 32'(ack_valid), 32'(exp_av));
    chk("parse_err", 32'(parse_err), 32'(exp_pe));
    chk("ack_value", 32'(ack_value), 32'(exp_val));
    chk("err_code",  32'(err_code),  32'(exp_err));
    chk("ack_count", 32'(ack_count), 32'(exp_cnt));
    chk("state_dbg", 32'(state_dbg), 32'(exp_state()));
  endtask

  task automatic tick(input logic v, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    exp_av = 0;
    exp_pe = 0;
    if (v) model_byte(d);
    if (parse_err) n_err_pulses++;
    check_all();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) tick(1'b1, s[i]);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_line();
    logic [7:0] bq[$];
    string      s;
    int         n, mode, idx;
    n    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 99999));
    mode = int'($urandom_range(0, 9));
    s = "ACK ";
    for (int z = int'($urandom_range(0, 3)); z > 2; z--) s = {s, "0"};
    if ($urandom_range(0, 3) == 0) s = {s, "0"};
    s = {s, $sformatf("%0d", n)};
    for (int i = 0; i < s.len(); i++) bq.push_back(s[i]);
    case (mode)
      6: begin
        idx = int'($urandom_range(0, bq.size() - 1));
        bq[idx] = 8'($urandom_range(32, 126));
      end
      7: begin
        idx = int'($urandom_range(0, bq.size()));
        while (bq.size() > idx) void'(bq.pop_back());
      end
      8: begin
        idx = int'($urandom_range(0, bq.size()));
        bq.insert(idx, 8'h0D);
      end
      9: bq.delete(3);
      default: ;
    endcase
    for (int i = 0; i < bq.size(); i++) begin
      if ($urandom_range(0, 3) == 0) tick(1'b0, 8'($urandom));
      tick(1'b1, bq[i]);
    end
    if ($urandom_range(0, 4) == 0) tick(1'b1, 8'h0D);
    tick(1'b1, 8'h0A);
  endtask

  int e0;

  initial begin
    hdr[0] = 8'h41; hdr[1] = 8'h43; hdr[2] = 8'h4B; hdr[3] = 8'h20;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back good line
    e0 = n_err_pulses;
    send_str("ACK 100\n");
    chk("t1_value", 32'(ack_value), 32'd100);
    chk("t1_count", 32'(ack_count), 32'd1);
    tick(1'b0, 8'h00);
    chk("t1_no_err", 32'(n_err_pulses - e0), 32'd0);

    // range limit, CR ignored, then overflow on the last digit
    send_str("ACK 65535");
    tick(1'b1, 8'h0D);
    tick(1'b1, 8'h0A);
    chk("t2_max", 32'(ack_value), 32'd65535);
    send_str("ACK 6553");
    tick(1'b1, 8'h36);
    chk("t2_ovf_pulse", 32'(parse_err), 32'd1);
    chk("t2_ovf_code", 32'(err_code), 32'd2);
    tick(1'b1, 8'h0A);
    chk("t2_hold", 32'(ack_value), 32'd65535);

    // bad header char then a good line
    e0 = n_err_pulses;
    send_str("ACX 5\nACK 7\n");
    tick(1'b0, 8'h00);
    chk("t3_code", 32'(err_code), 32'd1);
    chk("t3_value", 32'(ack_value), 32'd7);
    chk("t3_pulses", 32'(n_err_pulses - e0), 32'd1);

    // empty number, then too many digits
    send_str("ACK \n");
    chk("t4_empty", 32'(err_code), 32'd3);
    send_str("ACK 000012\n");
    chk("t4_digits", 32'(err_code), 32'd2);

    // reset mid-line
    send_str("ACK 12");
    do_reset(2);
    send_str("3\nACK 9\n");
    chk("t5_value", 32'(ack_value), 32'd9);
    chk("t5_count", 32'(ack_count), 32'd1);
    chk("t5_code", 32'(err_code), 32'd1);

    // counter wrap under continuous in_valid
    do_reset(1);
    for (int i = 0; i < 257; i++) send_str("ACK 1\n");
    chk("t6_wrap", 32'(ack_count), 32'd1);

    // randomised lines with gaps, CRs and corruption
    for (int i = 0; i < 250; i++) begin
      rand_line();
      if ($urandom_range(0, 60) == 0) do_reset(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
